// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master controller.
package spi_pkg;

  localparam int unsigned NBITS_DEFAULT       = 34;
  localparam int unsigned HALF_PERIOD_DEFAULT = 4;
  localparam int unsigned PHASE_CNT_W         = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CS_SETUP  = 3'd1,
    SCLK_HIGH = 3'd2,
    SCLK_LOW  = 3'd3,
    CS_HOLD   = 3'd4,
    DONE      = 3'd5
  } state_t;

endpackage

// File: rtl/spi_clk_phase_counter.sv
// Down-counter timing one sclk half-period; restarted on every phase entry.
module spi_clk_phase_counter
  import spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic phase_done_c
);

  logic [PHASE_CNT_W-1:0] cnt;

  // Load HALF_PERIOD-1 on phase entry, then count down and park at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= PHASE_CNT_W'(HALF_PERIOD - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - PHASE_CNT_W'(1);
    end
  end

  // Zero marks the last cycle of the current phase
  assign phase_done_c = (cnt == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 master: shifts one NBITS packet each way per transaction, MSB first.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned NBITS       = NBITS_DEFAULT,
  parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] send_msg,
  input  logic             send_val,
  output logic             send_rdy,
  output logic [NBITS-1:0] recv_msg,
  output logic             recv_val,
  input  logic             recv_rdy,
  output logic             recv_parity,
  output logic             cs,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned BIT_CNT_W = $clog2(NBITS + 1);

  state_t               state;
  state_t               state_next;
  logic [NBITS-1:0]     tx_shift;
  logic [NBITS-1:0]     rx_shift;
  logic [BIT_CNT_W-1:0] bit_cnt;

  logic phase_done_c;
  logic phase_load_c;
  logic handshake_c;
  logic enter_high_c;
  logic enter_low_c;
  logic enter_done_c;

  logic cs_d;
  logic sclk_d;
  logic send_rdy_d;
  logic recv_val_d;

  assign handshake_c  = send_val && send_rdy;
  assign phase_load_c = (state_next != state);
  assign enter_high_c = (state_next == SCLK_HIGH) && (state != SCLK_HIGH);
  assign enter_low_c  = (state_next == SCLK_LOW)  && (state != SCLK_LOW);
  assign enter_done_c = (state_next == DONE)      && (state != DONE);

  spi_clk_phase_counter #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_phase_cnt (
    .clk          (clk),
    .reset        (reset),
    .load         (phase_load_c),
    .phase_done_c (phase_done_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: each timed phase lasts until the phase counter expires
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (handshake_c)  state_next = CS_SETUP;
      CS_SETUP:  if (phase_done_c) state_next = SCLK_HIGH;
      SCLK_HIGH: if (phase_done_c) begin
                   state_next = (bit_cnt < BIT_CNT_W'(NBITS)) ? SCLK_LOW : CS_HOLD;
                 end
      SCLK_LOW:  if (phase_done_c) state_next = SCLK_HIGH;
      CS_HOLD:   if (phase_done_c) state_next = DONE;
      DONE:      if (recv_rdy)     state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output decode from the next state so the registered pins line up with the state
  always_comb begin
    cs_d       = 1'b1;
    sclk_d     = 1'b0;
    send_rdy_d = 1'b0;
    recv_val_d = 1'b0;
    case (state_next)
      IDLE:      send_rdy_d = 1'b1;
      CS_SETUP:  cs_d = 1'b0;
      SCLK_HIGH: begin
                   cs_d   = 1'b0;
                   sclk_d = 1'b1;
                 end
      SCLK_LOW:  cs_d = 1'b0;
      CS_HOLD:   cs_d = 1'b0;
      DONE:      recv_val_d = 1'b1;
      default:   ;
    endcase
  end

  // Control output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cs       <= 1'b1;
      sclk     <= 1'b0;
      send_rdy <= 1'b1;
      recv_val <= 1'b0;
    end else begin
      cs       <= cs_d;
      sclk     <= sclk_d;
      send_rdy <= send_rdy_d;
      recv_val <= recv_val_d;
    end
  end

  // Shift registers: sample miso as sclk rises, advance mosi as sclk falls
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      mosi        <= 1'b0;
      recv_msg    <= '0;
      recv_parity <= 1'b0;
    end else begin
      if (handshake_c) begin
        tx_shift <= send_msg;
        rx_shift <= '0;
        bit_cnt  <= '0;
        mosi     <= send_msg[NBITS-1];
      end
      if (enter_high_c) begin
        rx_shift <= {rx_shift[NBITS-2:0], miso};
        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
      end
      if (enter_low_c) begin
        tx_shift <= {tx_shift[NBITS-2:0], 1'b0};
        mosi     <= tx_shift[NBITS-2];
      end
      if (enter_done_c) begin
        recv_msg    <= rx_shift;
        recv_parity <= ^rx_shift;
      end
    end
  end

endmodule
